// File: rtl/rom_fetch_unit.sv
// Instruction prefetcher: issues word reads to a fixed-latency ROM and buffers them in a small FIFO.
// Optional ROMFETCH_ALIGN_CHK_EN: misaligned redirects are rejected and latch a sticky fetch_err.
module rom_fetch_unit #(
  parameter logic [14:0] RESET_PC   = 15'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        mbist_busy,
  input  logic        redirect_valid,
  input  logic [14:0] redirect_pc,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [14:0] instr_pc,
  output logic        fetch_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_W  = PW'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [14:0] pc;
  } entry_t;

  state_t        state, next_state;
  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          inflight;
  logic [14:0]   pc, tag_pc;
  logic          redir_take;
  logic [14:0]   redir_target;
  logic          push, pop;

`ifdef ROMFETCH_ALIGN_CHK_EN
  assign redir_take   = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_target = redirect_pc;

  always_ff @(posedge clk) begin
    if (rst)
      fetch_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      fetch_err <= 1'b1;
  end
`else
  logic unused_pc_lsbs;

  assign redir_take     = redirect_valid;
  assign redir_target   = {redirect_pc[14:2], 2'b00};
  assign fetch_err      = 1'b0;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_W) ? '0 : p + 1'b1;
  endfunction

  // Slots already promised to the outstanding read count as occupied.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    rom_req    = 1'b0;
    case (state)
      IDLE: if (fetch_en) next_state = RUN;
      RUN: begin
        if (!fetch_en) next_state = IDLE;
        rom_req = fetch_en && !mbist_busy && !redir_take && (occupancy < DEPTH_W);
      end
    endcase
  end

  assign instr_valid = (count != '0);
  assign push        = rom_ready && inflight && !redir_take;
  assign pop         = instr_valid && instr_ready && !redir_take;
  assign rom_addr    = pc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redir_take) begin
      // Dropping inflight discards the response still on its way back.
      pc       <= redir_target;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= rom_req;
      if (rom_req) begin
        tag_pc <= pc;
        pc     <= pc + 15'd4;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count alone decides which entries are live, and the outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: rom_rdata, pc: tag_pc};
  end

  assign instr_data = instr_valid ? mem[rd_ptr].data : '0;
  assign instr_pc   = instr_valid ? mem[rd_ptr].pc   : '0;

endmodule

// File: doc/rom_fetch_unit.md
ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 15'h0000, byte address of first fetch after reset; bits [1:0] are zero.
REQ-002 Parameter: FIFO_DEPTH, 4, prefetch buffer entries; legal 2..8; one instruction per cycle requires at least 3.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 fetch_en  in  1  1 = issue fetches; 0 = stop issuing and drain.
REQ-007 mbist_busy  in  1  ROM under MBIST; no new requests while high.
REQ-008 redirect_valid  in  1  load new fetch PC this cycle.
REQ-009 redirect_pc  in  15  new fetch byte address.
REQ-010 rom_req  out  1  read request to the ROM controller.
REQ-011 rom_addr  out  15  byte address of the request; word-aligned.
REQ-012 rom_rdata  in  32  ROM read data; valid when rom_ready=1.
REQ-013 rom_ready  in  1  response strobe, exactly one cycle after the cycle rom_req was high.
REQ-014 instr_valid  out  1  instr_data and instr_pc valid.
REQ-015 instr_ready  in  1  consumer accepts; pop on instr_valid && instr_ready.
REQ-016 instr_data  out  32  fetched word, FIFO head.
REQ-017 instr_pc  out  15  byte address of instr_data.
REQ-018 fetch_err  out  1  sticky misaligned-redirect flag.

Function
REQ-019 States: IDLE, RUN. IDLE->RUN when fetch_en=1. RUN->IDLE when fetch_en=0; the transition takes effect the same cycle, so no request issues in that cycle.
REQ-020 rom_req SHALL be combinational: 1 iff state=RUN, fetch_en=1, mbist_busy=0, redirect_valid=0, and count+inflight < FIFO_DEPTH. count and inflight are the registered values, with no same-cycle pop lookahead.
REQ-021 rom_addr SHALL equal the fetch PC register at all times.
REQ-022 At each edge with rom_req=1: inflight:=1 tagged with the PC; PC:=PC+4, modulo 2^15, so 15'h7FFC wraps to 15'h0000. Otherwise inflight:=0.
REQ-023 At an edge with rom_ready=1 and inflight=1 not flushed: push {rom_rdata, tagged PC}. Push and pop in the same cycle SHALL both take effect.
REQ-024 rom_ready=1 while inflight=0 SHALL be ignored.
REQ-025 Redirect at edge N has priority over pop, push and issue. Effects at edge N:
- FIFO emptied.
- An inflight response arriving at edge N+1 is dropped.
- PC:=redirect_pc.
- instr_valid is 0 in the cycle after N.
REQ-026 Redirect timing: rom_req=1 with rom_addr=redirect_pc in the cycle after N. instr_valid=1 with that word in the cycle after edge N+2.
REQ-027 Redirect SHALL be honoured in IDLE: it updates the PC and flushes the FIFO.
REQ-028 mbist_busy=1 or fetch_en=0 blocks only new requests. The outstanding response is still captured, and the FIFO keeps draining.
REQ-029 Full FIFO: no request issues. Empty FIFO: instr_valid=0. instr_data and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.

Reset
REQ-030 On rst=1 at an edge:
- state:=IDLE, PC:=RESET_PC, count:=0, inflight:=0.
- Outputs become: rom_req=0, rom_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_err=0.
REQ-031 Reset mid-operation SHALL discard all FIFO contents and any in-flight response; rom_ready in the following cycle is ignored.

Configuration
REQ-032 Macro ROMFETCH_ALIGN_CHK_EN, when defined: a redirect with redirect_pc[1:0]!=0 is ignored (no flush, PC unchanged) and sets fetch_err=1 until reset.
REQ-033 Macro ROMFETCH_ALIGN_CHK_EN, when undefined: redirect_pc[1:0] is treated as 2'b00 and fetch_err is tied to 0.

Verification
REQ-034 Reset, fetch_en=1, instr_ready=1, ROM word i=32'hDEAD_0000+i -> rom_addr 0x0000, 0x0004, 0x0008 on consecutive cycles; instr_data DEAD0000, DEAD0001, DEAD0002 on consecutive cycles, with no bubbles.
REQ-035 instr_ready=0 for 10 cycles -> exactly 4 pushes, then rom_req=0; instr_data=DEAD0000 held stable; resuming yields an unbroken sequence.
REQ-036 Redirect to 0x0100 while a request is in flight -> stale word dropped; rom_addr=0x0100 next cycle; first instr_pc=0x0100 with instr_data=DEAD0040, three cycles after the redirect.
REQ-037 RESET_PC=15'h7FF8 -> instr_pc sequence 7FF8, 7FFC, 0000.
REQ-038 mbist_busy=1 for 20 cycles mid-stream -> rom_req=0 throughout; the in-flight word is still delivered; after mbist_busy falls the stream resumes with no skipped or duplicated PC.
REQ-039 With ROMFETCH_ALIGN_CHK_EN, redirect_pc=0x0102 -> fetch_err=1, and the stream continues from the old PC.
